// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, receive-enable FSM encoding and the
// default bit timing used by the matching receiver.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int CLKS_PER_BIT = 87;

    typedef enum logic {
        s_HOLD  = 1'b0,
        s_ARMED = 1'b1
    } rx_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver, the receive FIFO and its consumer.
// The slave modport is the FIFO's view; the master modport is the environment's view.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic                   i_Rx_DV;
    logic [UART_DATA_W-1:0] i_Rx_Byte;
    logic                   o_Receive;
    logic [UART_DATA_W-1:0] o_Data;
    logic                   o_Valid;
    logic                   i_Ready;
    logic [ADDR_W:0]        o_Count;
    logic                   o_Full;
    logic                   i_Clear_Overflow;
    logic                   o_Overflow;

    modport slave (
        input  i_Rx_DV,
        input  i_Rx_Byte,
        output o_Receive,
        output o_Data,
        output o_Valid,
        input  i_Ready,
        output o_Count,
        output o_Full,
        input  i_Clear_Overflow,
        output o_Overflow
    );

    modport master (
        output i_Rx_DV,
        output i_Rx_Byte,
        input  o_Receive,
        input  o_Data,
        input  o_Valid,
        output i_Ready,
        input  o_Count,
        input  o_Full,
        output i_Clear_Overflow,
        input  o_Overflow
    );

endinterface : uart_rx_fifo_if

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   i_Clock,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Write port: store the accepted byte at the write pointer.
    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: first-word-fall-through FIFO with
// sticky overflow and a hysteretic receive enable that guarantees free space.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic           i_Clock,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   HI_MARK  = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [ADDR_W:0]   LO_MARK  = (ADDR_W+1)'(DEPTH - AFULL_MARGIN - 1);
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   valid_q, valid_d;
    logic                   full_q, full_d;
    logic                   overflow_q, overflow_d;
    rx_state_e              state_q, state_d;
    logic                   push_s, pop_s, drop_s, mem_we_s;
    logic [UART_DATA_W-1:0] rd_data_s;

    // Handshake decode, pointer/count advance and status flags.
    always_comb begin
        pop_s      = valid_q & bus.i_Ready;
        push_s     = bus.i_Rx_DV & ((count_q != CNT_FULL) | pop_s);
        drop_s     = bus.i_Rx_DV & (count_q == CNT_FULL) & ~pop_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear must leave the flag set.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (bus.i_Clear_Overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        valid_d = (count_d != {(ADDR_W+1){1'b0}});
        full_d  = (count_d == CNT_FULL);
    end

    // Receive-enable FSM, evaluated on the count being registered this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_HOLD: begin
                if (count_d <= LO_MARK) begin
                    state_d = s_ARMED;
                end else begin
                    state_d = s_HOLD;
                end
            end
            s_ARMED: begin
                if (count_d >= HI_MARK) begin
                    state_d = s_HOLD;
                end else begin
                    state_d = s_ARMED;
                end
            end
            default: state_d = s_HOLD;
        endcase
    end

    // State registers; reset discards stored bytes but leaves memory untouched.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W+1){1'b0}};
            valid_q    <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= s_HOLD;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign mem_we_s = push_s & ~reset;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_Clock (i_Clock),
        .wr_en   (mem_we_s),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.i_Rx_Byte),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    assign bus.o_Data     = rd_data_s;
    assign bus.o_Valid    = valid_q;
    assign bus.o_Count    = count_q;
    assign bus.o_Full     = full_q;
    assign bus.o_Overflow = overflow_q;
    assign bus.o_Receive  = (state_q == s_ARMED);

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic i_Clock = 1'b0;
    logic reset   = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    logic [7:0] mq[$];
    bit         m_ovf   = 1'b0;
    bit         m_armed = 1'b0;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .AFULL_MARGIN(2)) dut (
        .i_Clock (i_Clock),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 i_Clock = ~i_Clock;

    // One clock cycle with the given inputs; the model advances at the edge.
    task automatic step(input logic dv, input logic [7:0] b, input logic rdy,
                        input logic clr, input logic rst);
        bit pop;
        bit was_full;
        bus.i_Rx_DV          = dv;
        bus.i_Rx_Byte        = b;
        bus.i_Ready          = rdy;
        bus.i_Clear_Overflow = clr;
        reset                = rst;
        @(posedge i_Clock);
        if (rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_armed = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop      = rdy && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (dv) begin
                if (!was_full || pop) mq.push_back(b);
                else m_ovf = 1'b1;
            end
            if (!(dv && was_full && !pop) && clr) m_ovf = 1'b0;
            if (!m_armed && mq.size() <= DEPTH - 3) m_armed = 1'b1;
            else if (m_armed && mq.size() >= DEPTH - 2) m_armed = 1'b0;
        end
        @(negedge i_Clock);
        bus.i_Rx_DV          = 1'b0;
        bus.i_Ready          = 1'b0;
        bus.i_Clear_Overflow = 1'b0;
        reset                = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_Valid); end
            checks++; if (bus.o_Count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.o_Count); end
            checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.o_Overflow); end
            checks++; if (bus.o_Receive !== 1'b0) begin errors++; $display("FAIL reset_receive: got %b want 0", bus.o_Receive); end
            checks++; if (bus.o_Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.o_Full); end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.o_Receive !== 1'b1) begin errors++; $display("FAIL release_receive: got %b want 1", bus.o_Receive); end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.o_Valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.o_Valid); end
        checks++; if (bus.o_Data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h want a5", bus.o_Data); end
        checks++; if (bus.o_Count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.o_Count); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b want 0", bus.o_Valid); end
        checks++; if (bus.o_Count !== 5'd0) begin errors++; $display("FAIL single_pop_count: got %0d want 0", bus.o_Count); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_Count !== 5'd0) begin errors++; $display("FAIL ready_when_empty: got %0d want 0", bus.o_Count); end
    endtask

    task automatic test_flow_wrap();
        logic [7:0] base;
        for (int r = 0; r < 2; r++) begin
            base = (r == 0) ? 8'h00 : 8'h40;
            for (int i = 0; i < DEPTH; i++) begin
                step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
                checks++; if (bus.o_Count !== 5'(i + 1)) begin errors++; $display("FAIL flow_count r%0d i%0d: got %0d want %0d", r, i, bus.o_Count, i + 1); end
                checks++; if (bus.o_Receive !== ((i + 1) <= 13)) begin errors++; $display("FAIL flow_receive r%0d i%0d: got %b want %b", r, i, bus.o_Receive, ((i + 1) <= 13)); end
            end
            checks++; if (bus.o_Full !== 1'b1) begin errors++; $display("FAIL flow_full r%0d: got %b want 1", r, bus.o_Full); end
            checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL flow_ovf r%0d: got %b want 0", r, bus.o_Overflow); end
            for (int k = 1; k <= DEPTH; k++) begin
                checks++; if (bus.o_Data !== base + 8'(k - 1)) begin errors++; $display("FAIL flow_data r%0d k%0d: got %h want %h", r, k, bus.o_Data, base + 8'(k - 1)); end
                step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                checks++; if (bus.o_Receive !== ((DEPTH - k) <= 13)) begin errors++; $display("FAIL drain_receive r%0d k%0d: got %b want %b", r, k, bus.o_Receive, ((DEPTH - k) <= 13)); end
            end
            checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL flow_empty r%0d: got %b want 0", r, bus.o_Valid); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.o_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", bus.o_Overflow); end
        checks++; if (bus.o_Count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", bus.o_Count); end
        step(1'b1, 8'h78, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.o_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b want 1", bus.o_Overflow); end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.o_Overflow); end
        while (mq.size() > 0) begin
            checks++; if (bus.o_Data !== mq[0]) begin errors++; $display("FAIL ovf_drain_data: got %h want %h", bus.o_Data, mq[0]); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_Count !== 5'd16) begin errors++; $display("FAIL simul_full_count: got %0d want 16", bus.o_Count); end
        checks++; if (bus.o_Overflow !== 1'b0) begin errors++; $display("FAIL simul_full_ovf: got %b want 0", bus.o_Overflow); end
        while (mq.size() > 0) begin
            if (mq.size() == 1) begin
                checks++; if (bus.o_Data !== 8'h55) begin errors++; $display("FAIL simul_last: got %h want 55", bus.o_Data); end
            end
            checks++; if (bus.o_Data !== mq[0]) begin errors++; $display("FAIL simul_drain_data: got %h want %h", bus.o_Data, mq[0]); end
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_Count !== 5'd1) begin errors++; $display("FAIL simul_one_count: got %0d want 1", bus.o_Count); end
        checks++; if (bus.o_Data !== 8'hC3) begin errors++; $display("FAIL simul_one_data: got %h want c3", bus.o_Data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic dv, rdy, clr;
        for (int n = 0; n < 600; n++) begin
            dv  = (n % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rdy = (n % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            if (mq.size() > 0) begin
                checks++; if (bus.o_Data !== mq[0]) begin errors++; $display("FAIL rand_data n%0d: got %h want %h", n, bus.o_Data, mq[0]); end
            end
            step(dv, 8'($urandom_range(0, 255)), rdy, clr, 1'b0);
            checks++; if (bus.o_Count !== 5'(mq.size())) begin errors++; $display("FAIL rand_count n%0d: got %0d want %0d", n, bus.o_Count, mq.size()); end
            checks++; if (bus.o_Valid !== (mq.size() > 0)) begin errors++; $display("FAIL rand_valid n%0d: got %b want %b", n, bus.o_Valid, (mq.size() > 0)); end
            checks++; if (bus.o_Full !== (mq.size() == DEPTH)) begin errors++; $display("FAIL rand_full n%0d: got %b want %b", n, bus.o_Full, (mq.size() == DEPTH)); end
            checks++; if (bus.o_Overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf n%0d: got %b want %b", n, bus.o_Overflow, m_ovf); end
            checks++; if (bus.o_Receive !== m_armed) begin errors++; $display("FAIL rand_receive n%0d: got %b want %b", n, bus.o_Receive, m_armed); end
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        checks++; if (bus.o_Count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", bus.o_Count); end
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.o_Count !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.o_Count); end
        checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", bus.o_Valid); end
        checks++; if (bus.o_Receive !== 1'b0) begin errors++; $display("FAIL mid_receive: got %b want 0", bus.o_Receive); end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.o_Valid !== 1'b0) begin errors++; $display("FAIL mid_no_delivery: got %b want 0", bus.o_Valid); end
        checks++; if (bus.o_Receive !== 1'b1) begin errors++; $display("FAIL mid_rearm: got %b want 1", bus.o_Receive); end
    endtask

    initial begin
        bus.i_Rx_DV          = 1'b0;
        bus.i_Rx_Byte        = 8'h00;
        bus.i_Ready          = 1'b0;
        bus.i_Clear_Overflow = 1'b0;
        test_reset();
        test_single();
        test_flow_wrap();
        test_overflow();
        test_simultaneous();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver flags with its one-cycle done pulse and stores it in a power-of-two circular FIFO.
- Presents bytes first-word-fall-through to the consumer with a valid/ready handshake.
- Drives the receiver's `receive` enable so the receiver only re-arms when free space is guaranteed. A sticky overflow flag reports any byte dropped.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 4.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).
- AFULL_MARGIN, 2, free entries required before o_Receive stays high; minimum 1, because one byte can still arrive after o_Receive drops.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- i_Rx_DV  input  1  byte-done pulse from the UART receiver.
- i_Rx_Byte  input  8  received byte; valid when i_Rx_DV=1.
- o_Receive  output  1  receive enable to the UART receiver.
- o_Data  output  8  head-of-FIFO byte; valid when o_Valid=1.
- o_Valid  output  1  FIFO non-empty; o_Data is meaningful.
- i_Ready  input  1  consumer accepts o_Data this cycle.
- o_Count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Full  output  1  o_Count==DEPTH.
- i_Clear_Overflow  input  1  clears o_Overflow.
- o_Overflow  output  1  sticky: a byte was dropped.

Behaviour:
- Reset, sampled at a rising edge with reset=1:
  - write pointer, read pointer and count cleared to 0;
  - o_Valid=0, o_Full=0, o_Overflow=0, o_Receive=0;
  - memory contents are not cleared, and o_Data is don't-care while o_Valid=0.
  - Reset asserted mid-stream discards all stored bytes; any i_Rx_DV in a reset cycle is ignored.
- Push:
  - push_req = i_Rx_DV.
  - Accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
  - On accept: mem[wr_ptr]<=i_Rx_Byte, and wr_ptr increments modulo DEPTH (natural ADDR_W-bit wrap).
- Pop:
  - pop = o_Valid & i_Ready.
  - rd_ptr increments modulo DEPTH.
  - i_Ready while o_Valid=0 has no effect.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Outputs:
  - o_Valid, o_Full and o_Count are registered.
  - o_Data = mem[rd_ptr], read combinationally from the registered pointer.
- Latency:
  - A byte pushed at edge N is visible (o_Valid=1, o_Data=byte) after edge N, i.e. in cycle N+1.
  - A push into an empty FIFO cannot be popped in the same cycle.
- Overflow:
  - A push rejected because the FIFO is full with no pop sets o_Overflow at that edge; the byte is dropped and the pointers are unchanged.
  - i_Clear_Overflow clears o_Overflow at the next edge.
  - If an overflow and a clear occur in the same cycle, set wins.
- o_Receive control, a two-state machine:
  - s_HOLD, the reset state: o_Receive=0. Move to s_ARMED when next_count <= DEPTH-AFULL_MARGIN-1.
  - s_ARMED: o_Receive=1. Move to s_HOLD when next_count >= DEPTH-AFULL_MARGIN.
  - next_count is the count value being registered this cycle, so o_Receive and o_Count change on the same edge.
  - First o_Receive=1 appears one cycle after reset deasserts.
- Receiver interaction: the receiver samples `receive` only while idle. With AFULL_MARGIN>=1, a byte already in flight when o_Receive falls always finds a free slot, so overflow is impossible under correct use.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8;
  - the o_Receive FSM state encodings s_HOLD=1'b0 and s_ARMED=1'b1;
  - default CLKS_PER_BIT, shared with the receiver.
- One sub-module, uart_fifo_mem: DEPTH x 8 register array with one synchronous write port and one asynchronous read port.
- Pointers, count, flags and FSM live in uart_rx_fifo.

Test Plan:
- Reset: hold reset 3 cycles, then release -> during reset o_Valid=0, o_Count=0, o_Overflow=0, o_Receive=0; o_Receive=1 on the first cycle after release.
- Single byte: i_Rx_DV pulse with 0xA5, i_Ready=0 -> next cycle o_Valid=1, o_Data=0xA5, o_Count=1. Raise i_Ready for 1 cycle -> o_Valid=0, o_Count=0.
- Flow control and wrap-around:
  - Push 0x00..0x0D with no pops -> o_Receive falls on the edge where o_Count becomes 14.
  - Push 0x0E, 0x0F -> o_Full=1, o_Overflow=0.
  - Pop all 16 -> data arrives in order 0x00..0x0F, o_Receive rises when o_Count becomes 13.
  - Repeat the sequence to cross the pointer wrap.
- Overflow:
  - At count 16, push 0x77 with i_Ready=0 -> byte dropped, o_Overflow=1, o_Count stays 16.
  - Assert i_Clear_Overflow together with another dropped push -> o_Overflow stays 1.
  - Assert i_Clear_Overflow alone -> o_Overflow=0.
- Simultaneous events:
  - At count 16, push 0x55 and pop in the same cycle -> accepted, count stays 16, no overflow, 0x55 emerges last.
  - At count 1, push and pop together -> count stays 1.
- Reset mid-stream: with 5 bytes stored, assert reset for one cycle alongside an i_Rx_DV pulse -> count=0, o_Valid=0, o_Receive=0, and the pulsed byte is never delivered.
